// File: rtl/demux_pkg.sv
// Shared definitions for the demux_stream_n stream demultiplexer:
// per-channel slot states, statistics counter width/limit and the
// select-width helper. Optional statistics are enabled by the
// DEMUX_STREAM_STATS_EN macro.
package demux_pkg;

  // Occupancy of one per-channel output buffer
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  localparam int          STAT_W   = 16;
  localparam logic [15:0] STAT_MAX = 16'hFFFF;

  // Ceiling log2, used to size the channel select
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output buffer for a single demux channel. A load writes the
// word and marks the slot full; a drain with no simultaneous load empties
// it. With DEMUX_STREAM_STATS_EN defined the slot also keeps a saturating
// count of loaded words.
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain,
  output logic             valid,
  output logic [WIDTH-1:0] data
`ifdef DEMUX_STREAM_STATS_EN
  ,
  output logic [STAT_W-1:0] count
`endif
);

  slot_state_t      state_p1;
  logic [WIDTH-1:0] data_p1;

  // Slot FSM: load wins over drain so back-to-back words keep full rate
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p1 <= SLOT_EMPTY;
      data_p1  <= '0;
    end else if (load) begin
      state_p1 <= SLOT_FULL;
      data_p1  <= load_data;
    end else if (drain && (state_p1 == SLOT_FULL)) begin
      state_p1 <= SLOT_EMPTY;
    end
  end

  assign valid = (state_p1 == SLOT_FULL);
  assign data  = data_p1;

`ifdef DEMUX_STREAM_STATS_EN
  logic [STAT_W-1:0] count_p1;

  // Accepted-word counter, sticks at its maximum rather than wrapping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_p1 <= '0;
    end else if (load && (count_p1 != STAT_MAX)) begin
      count_p1 <= count_p1 + 1'b1;
    end
  end

  assign count = count_p1;
`endif

endmodule

// File: rtl/demux_stream_n.sv
// Registered 1-to-N stream demultiplexer. Each input word is routed by
// in_sel into a one-entry buffer on its channel; every channel has its
// own valid/ready so a stalled consumer only blocks its own channel.
// Words with an out-of-range select are accepted, dropped and flagged on
// err_sel. Define DEMUX_STREAM_STATS_EN to add per-channel counters.
module demux_stream_n
  import demux_pkg::*;
#(
  parameter  int WIDTH    = 2,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = (clog2(CHANNELS) < 1) ? 1 : clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic                      err_sel
`ifdef DEMUX_STREAM_STATS_EN
  ,
  output logic [CHANNELS*STAT_W-1:0] stat_count
`endif
);

  logic sel_ok;
  logic sel_free;
  logic accept;
  logic err_p1;

  // An out-of-range select is never stalled; the word is simply dropped
  assign sel_ok = (int'(in_sel) < CHANNELS);

  // Ready of the addressed channel only; other channels never gate input
  always_comb begin
    sel_free = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (in_sel == SEL_W'(i)) begin
        sel_free = ~out_valid[i] | out_ready[i];
      end
    end
  end

  assign in_ready = ~sel_ok | sel_free;
  assign accept   = in_valid & in_ready;

  // One-cycle error pulse for a dropped word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_p1 <= 1'b0;
    end else begin
      err_p1 <= accept & ~sel_ok;
    end
  end

  assign err_sel = err_p1;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_slot
    logic load;

    assign load = accept & sel_ok & (in_sel == SEL_W'(g));

    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .load_data(in_data),
      .drain    (out_ready[g]),
      .valid    (out_valid[g]),
      .data     (out_data[g*WIDTH +: WIDTH])
`ifdef DEMUX_STREAM_STATS_EN
      ,
      .count    (stat_count[g*STAT_W +: STAT_W])
`endif
    );
  end

endmodule

// File: doc/demux_stream_n.md
# demux_stream_n

Parametrised, registered 1-to-N stream demultiplexer: the next generation of the two-way demultiplexer. One input word of WIDTH bits, tagged with a channel select, is routed into a one-entry buffer on the selected output channel. Every channel has its own valid/ready handshake, so a stalled consumer blocks only its own channel. It sits between a single producer and CHANNELS independent consumers.

## Interface
- WIDTH, 2, data word width in bits (≥1)
- CHANNELS, 4, number of output channels (2..16)
- SEL_W, derived localparam = max(1, clog2(CHANNELS)), select width
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_data  in  WIDTH  input word
- in_sel  in  SEL_W  destination channel index
- in_valid  in  1  input word present
- in_ready  out  1  block can accept the word this cycle
- out_data  out  CHANNELS*WIDTH  channel i data at bits [i*WIDTH +: WIDTH]
- out_valid  out  CHANNELS  channel i buffer holds a word
- out_ready  in  CHANNELS  consumer i accepts this cycle
- err_sel  out  1  one-cycle pulse: word accepted with in_sel ≥ CHANNELS
- stat_count  out  CHANNELS*16  per-channel accepted-word counters (only with DEMUX_STREAM_STATS_EN)

## Operation
- Per channel two states: EMPTY, FULL; out_valid[i] = (state == FULL); out_data slice = buffer register.
- in_ready = 1 if in_sel ≥ CHANNELS; else (~out_valid[s] | out_ready[s]) with s = in_sel. Combinational from out_ready and in_sel.
- Accept = in_valid & in_ready. On accept with valid s: buffer[s] ← in_data, state[s] → FULL.
- Drain: out_valid[i] & out_ready[i] → state[i] → EMPTY, unless channel i is filled in the same cycle (then stays FULL with the new word).
- Invalid select accepted: word dropped, no buffer changes, err_sel = 1 next cycle for one cycle.
- While out_valid[i] & ~out_ready[i], out_data slice i is held stable.
- Channels are independent; only the channel addressed by in_sel affects in_ready.
- in_valid = 0: in_sel/in_data ignored, no state change.

## Timing
- Reset (rst_n = 0 at a rising edge): all states EMPTY, out_valid = 0, out_data = 0, err_sel = 0, stat_count = 0. Reset mid-transfer discards buffered words; nothing is emitted.
- Latency: word accepted at edge k appears as out_valid at cycle k+1.
- Throughput: one word per cycle per channel with continuous out_ready; back-to-back to the same channel sustains full rate.
- in_ready to out_ready is one combinational path; out_valid/out_data are registered.

## Configuration
- DEMUX_STREAM_STATS_EN defined: stat_count port present; counter i increments on each accept to channel i, saturates at 16'hFFFF, clears only on reset. Invalid-select words are not counted.
- Not defined: port and counters absent; all other behaviour identical.

## Structure
- Shared package/header demux_pkg: STAT_W = 16, STAT_MAX = 16'hFFFF, clog2 helper for SEL_W.
- Sub-module demux_slot: one-entry buffer (state, data, optional counter), load/drain inputs, instantiated CHANNELS times in a generate loop.

## Test plan
- Reset: rst_n low 2 cycles with in_valid = 1 → out_valid = 0, out_data = 0, err_sel = 0, in_ready high once released.
- Routing (WIDTH=2, CHANNELS=4): send 2'b01→ch0, 2'b10→ch1, 2'b11→ch3, all out_ready = 1 → each appears one cycle later on only its channel.
- Backpressure: out_ready[2] = 0, send 2'b11 then 2'b01 to ch2 → first held stable, in_ready = 0 for second; raise out_ready[2] → second accepted same cycle, visible next cycle; ch0 traffic unaffected throughout.
- Simultaneous drain+fill: ch1 FULL with 2'b10, out_ready[1] = 1 and new 2'b01 to ch1 → out_valid[1] stays 1, data becomes 2'b01.
- Invalid select (CHANNELS=3, in_sel = 3): in_ready = 1, err_sel pulses once, no out_valid change.
- Stats build: 70000 accepts to ch0 → stat_count ch0 = 16'hFFFF, others 0; reset clears to 0.
